qdec_reg_axi_mst: RTL

Single-outstanding register-bus initiator. It accepts simple read and write commands from a local controller, such as the decoder sequencer or a debug bridge. It drives the `t_reg_req_s` request bundle from `qdec_axi_pkg` and consumes `t_reg_resp_s` from the register slaves. It adds transaction-ID tagging, stale-response draining and a timeout that guarantees the local side always gets a response.

---
 rtl/qdec_reg_axi_mst.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/qdec_reg_axi_mst.sv
// Register-bus types shared with the register slaves, and a single-outstanding
// initiator that tags each transaction with an ID, drains stale beats and times out.
package qdec_axi_pkg;
    localparam int R_AWID  = 32;
    localparam int R_DWID  = 32;
    localparam int R_IDWID = 8;
    localparam logic [R_DWID-1:0] REG_BAD_DATA = 32'hDEAD_ADDE;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } t_AXI_RESP_e;

    typedef struct packed {
        logic                clk_en;
        logic [R_IDWID-1:0]  awid;
        logic [R_AWID-1:0]   awaddr;
        logic                awvalid;
        logic [R_DWID-1:0]   wdata;
        logic [R_DWID/8-1:0] wstrb;
        logic                wvalid;
        logic                bready;
        logic [R_IDWID-1:0]  arid;
        logic [R_AWID-1:0]   araddr;
        logic                arvalid;
        logic                rready;
    } t_reg_req_s;

    typedef struct packed {
        logic               awready;
        logic               wready;
        logic [R_IDWID-1:0] bid;
        t_AXI_RESP_e        bresp;
        logic               bvalid;
        logic               arready;
        logic [R_IDWID-1:0] rid;
        logic [R_DWID-1:0]  rdata;
        t_AXI_RESP_e        rresp;
        logic               rvalid;
    } t_reg_resp_s;
endpackage

module qdec_reg_axi_mst
    import qdec_axi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [7:0]  ID_INIT     = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [R_AWID-1:0]   cmd_addr,
    input  logic [R_DWID-1:0]   cmd_wdata,
    input  logic [R_DWID/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [R_DWID-1:0]   rsp_rdata,
    output t_AXI_RESP_e         rsp_resp,
    output logic                rsp_timeout,
    output t_reg_req_s          reg_req,
    input  t_reg_resp_s         reg_resp
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_RSP
    } t_state_e;

    t_state_e           state_reg;
    t_reg_req_s         req_reg;
    logic [7:0]         id_reg;
    logic [15:0]        cnt_reg;
    logic               aw_done_reg;
    logic               w_done_reg;
    logic               rsp_valid_reg;
    logic [R_DWID-1:0]  rsp_rdata_reg;
    t_AXI_RESP_e        rsp_resp_reg;
    logic               rsp_timeout_reg;

    logic aw_done_next;
    logic w_done_next;
    logic ar_hs;
    logic b_match;
    logic r_match;
    logic in_wait;
    logic done_now;

    always_comb begin
        aw_done_next = aw_done_reg | (req_reg.awvalid & reg_resp.awready);
        w_done_next  = w_done_reg  | (req_reg.wvalid  & reg_resp.wready);
        ar_hs        = req_reg.arvalid & reg_resp.arready;
        b_match      = reg_resp.bvalid & (reg_resp.bid == id_reg);
        r_match      = reg_resp.rvalid & (reg_resp.rid == id_reg);
        in_wait      = (state_reg == S_WADDR) || (state_reg == S_WRESP) ||
                       (state_reg == S_RADDR) || (state_reg == S_RDATA);
        done_now     = ((state_reg == S_WADDR) && aw_done_next && w_done_next) ||
                       ((state_reg == S_WRESP) && b_match) ||
                       ((state_reg == S_RADDR) && ar_hs) ||
                       ((state_reg == S_RDATA) && r_match);
    end

    assign cmd_ready   = (state_reg == S_IDLE) && !rst;
    assign reg_req     = req_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_resp    = rsp_resp_reg;
    assign rsp_timeout = rsp_timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            req_reg         <= '0;
            id_reg          <= ID_INIT;
            cnt_reg         <= '0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_OKAY;
            rsp_timeout_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + 16'd1;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cnt_reg        <= '0;
                        req_reg.clk_en <= 1'b1;
                        if (cmd_write) begin
                            req_reg.awid    <= id_reg;
                            req_reg.awaddr  <= cmd_addr;
                            req_reg.awvalid <= 1'b1;
                            req_reg.wdata   <= cmd_wdata;
                            req_reg.wstrb   <= cmd_wstrb;
                            req_reg.wvalid  <= 1'b1;
                            aw_done_reg     <= 1'b0;
                            w_done_reg      <= 1'b0;
                            state_reg       <= S_WADDR;
                        end else begin
                            req_reg.arid    <= id_reg;
                            req_reg.araddr  <= cmd_addr;
                            req_reg.arvalid <= 1'b1;
                            state_reg       <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    // AW and W retire independently; each VALID drops after its own READY.
                    aw_done_reg <= aw_done_next;
                    w_done_reg  <= w_done_next;
                    if (aw_done_next) req_reg.awvalid <= 1'b0;
                    if (w_done_next)  req_reg.wvalid  <= 1'b0;
                    if (aw_done_next && w_done_next) begin
                        req_reg.bready <= 1'b1;
                        cnt_reg        <= '0;
                        state_reg      <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (b_match) begin
                        req_reg.bready  <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= reg_resp.bresp;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= S_RSP;
                    end
                end
                S_RADDR: begin
                    if (ar_hs) begin
                        req_reg.arvalid <= 1'b0;
                        req_reg.rready  <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (r_match) begin
                        req_reg.rready  <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= reg_resp.rdata;
                        rsp_resp_reg    <= reg_resp.rresp;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_reg       <= '0;
                        id_reg        <= id_reg + 8'd1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // A completing handshake in the last allowed cycle takes priority.
            if (in_wait && !done_now && (cnt_reg == CNT_LAST)) begin
                req_reg.awvalid <= 1'b0;
                req_reg.wvalid  <= 1'b0;
                req_reg.bready  <= 1'b0;
                req_reg.arvalid <= 1'b0;
                req_reg.rready  <= 1'b0;
                rsp_valid_reg   <= 1'b1;
                rsp_rdata_reg   <= REG_BAD_DATA;
                rsp_resp_reg    <= AXI_DECERR;
                rsp_timeout_reg <= 1'b1;
                state_reg       <= S_RSP;
            end
        end
    end

endmodule
